// File: rtl/alui_dispatch_fsm.sv
// alui_dispatch_fsm
// Fetch/dispatch controller that feeds the ALU-immediate FSM. It reads one
// 16-bit instruction per step from program memory and splits it into
// opCode/Ri/num. It pulses start to the downstream FSM and waits for done
// before it advances the program counter. A HALT opcode stops dispatch. A
// watchdog also stops the machine and sets a sticky error if done never
// arrives.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   run               level enable for fetching
//   mem_addr/mem_read program memory address (= pc) and one-cycle read strobe
//   mem_data          instruction word, valid the cycle after mem_read
//   start             one-cycle start pulse to the ALU-immediate FSM
//   opCode/Ri/num     instruction fields [15:12]/[11:6]/[5:0]
//   done              completion pulse from the ALU-immediate FSM
//   pc, instr_count   program counter, retired-instruction counter
//   busy/halted/error status: active, stopped, sticky watchdog timeout
module alui_dispatch_fsm #(
  parameter int          PC_W    = 8,
  parameter int          TIMEOUT = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_read,
  input  logic [15:0]     mem_data,
  output logic            start,
  output logic [3:0]      opCode,
  output logic [5:0]      Ri,
  output logic [5:0]      num,
  input  logic            done,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instr_count,
  output logic            busy,
  output logic            halted,
  output logic            error
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The watchdog expires in the WAIT_DONE cycle where it counts up to
  // TIMEOUT-1. In that cycle the count still holds TIMEOUT-2. The error is
  // therefore visible exactly TIMEOUT cycles after the start pulse.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_DONE, HALT
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wdog;
  logic            is_halt;
  logic            load_ir, retire, wd_clr, wd_inc, set_err;

  // opCode/Ri/num together form the instruction register.
  assign is_halt  = (opCode == HALT_OP);
  assign mem_addr = pc;

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    start     = 1'b0;
    load_ir   = 1'b0;
    retire    = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    set_err   = 1'b0;
    busy      = 1'b1;
    halted    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        mem_read  = 1'b1;
        state_nxt = WAIT_MEM;
      end
      WAIT_MEM: begin
        load_ir   = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (is_halt) begin
          state_nxt = HALT;
        end else begin
          start     = 1'b1;
          wd_clr    = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A done in the expiry cycle still retires the instruction.
        if (done) begin
          retire    = 1'b1;
          state_nxt = run ? FETCH : IDLE;
        end else if (wdog == WD_LAST) begin
          set_err   = 1'b1;
          state_nxt = HALT;
        end else begin
          wd_inc    = 1'b1;
        end
      end
      HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
      opCode      <= '0;
      Ri          <= '0;
      num         <= '0;
      wdog        <= '0;
      error       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_ir) begin
        opCode <= mem_data[15:12];
        Ri     <= mem_data[11:6];
        num    <= mem_data[5:0];
      end
      if (retire) begin
        pc          <= pc + PC_W'(1);
        instr_count <= instr_count + 16'd1;
      end
      if (wd_clr)       wdog <= '0;
      else if (wd_inc)  wdog <= wdog + WD_W'(1);
      if (set_err) error <= 1'b1;
    end
  end

endmodule
